// File: rtl/char_row_scaler.sv
// Glyph-row pixel expander: scales each glyph bit into an sx*sy block of coloured pixels,
// clips to the screen and streams one pixel per cycle. Optional macro: OSD_TRANSPARENT_BG_EN.
module char_row_scaler #(
    parameter int CHAR_PIC_WIDTH = 9,
    parameter int SCALE_W        = 3,
    parameter int MAX_SCALE      = 4,
    parameter int COLOR_WIDTH    = 24,
    parameter int SCREEN_WIDTH   = 1920,
    parameter int SCREEN_HEIGHT  = 1080
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [SCALE_W-1:0]        cfg_scale_x,
    input  logic [SCALE_W-1:0]        cfg_scale_y,
    input  logic [COLOR_WIDTH-1:0]    cfg_fg_color,
    input  logic [COLOR_WIDTH-1:0]    cfg_bg_color,
    input  logic                      cfg_bg_transparent,
    input  logic [CHAR_PIC_WIDTH-1:0] s_row_pixels_data,
    input  logic                      s_row_pixels_valid,
    output logic                      s_row_pixels_ready,
    input  logic [10:0]               s_row_pixels_posX,
    input  logic [10:0]               s_row_pixels_posY,
    output logic [COLOR_WIDTH-1:0]    m_pixel_data,
    output logic                      m_pixel_valid,
    input  logic                      m_pixel_ready,
    output logic [10:0]               m_pixel_posX,
    output logic [10:0]               m_pixel_posY
);
    localparam int W  = CHAR_PIC_WIDTH;
    localparam int CW = $clog2(CHAR_PIC_WIDTH);

    typedef enum logic {S_IDLE, S_EXPAND} state_t;
    state_t state_q, state_d;

    logic [W-1:0]           row_q, row_d, shift_q, shift_d;
    logic [11:0]            xbase_q, xbase_d, x_q, x_d, y_q, y_d;
    logic [CW-1:0]          col_q, col_d;
    logic [SCALE_W-1:0]     sxc_q, sxc_d, ryc_q, ryc_d, scx_q, scx_d, scy_q, scy_d;
    logic [COLOR_WIDTH-1:0] fg_q, fg_d, bg_q, bg_d, od_q, od_d;
    logic                   ov_q, ov_d;
    logic [10:0]            ox_q, ox_d, oy_q, oy_d;

    function automatic logic [SCALE_W-1:0] clamp_scale(input logic [SCALE_W-1:0] v);
        if (v == '0) return SCALE_W'(1);
        if (v > SCALE_W'(MAX_SCALE)) return SCALE_W'(MAX_SCALE);
        return v;
    endfunction

    logic advance, last_step, accept, idle_accept, step, emit, skip, clipped;
    logic [SCALE_W-1:0] in_scx, in_scy;

    assign in_scx      = clamp_scale(cfg_scale_x);
    assign in_scy      = clamp_scale(cfg_scale_y);
    assign advance     = !ov_q || m_pixel_ready;
    assign last_step   = (sxc_q == scx_q - SCALE_W'(1)) && (col_q == CW'(W-1)) &&
                         (ryc_q == scy_q - SCALE_W'(1));
    // Ready also rises on the final step so the next row is taken without a bubble.
    assign s_row_pixels_ready = !rst && advance &&
                                (state_q == S_IDLE || (state_q == S_EXPAND && last_step));
    assign accept      = s_row_pixels_valid && s_row_pixels_ready;
    assign idle_accept = accept && (state_q == S_IDLE);
    assign step        = idle_accept || (state_q == S_EXPAND && advance);

    // An idle acceptance performs step 0 straight from the inputs, giving 1-cycle latency.
    logic [W-1:0]           src_row, src_shift;
    logic [11:0]            src_xbase, src_x, src_y;
    logic [CW-1:0]          src_col;
    logic [SCALE_W-1:0]     src_sxc, src_ryc, src_scx;
    logic [COLOR_WIDTH-1:0] src_fg, src_bg;
    logic                   src_bit;

    assign src_row   = idle_accept ? s_row_pixels_data : row_q;
    assign src_shift = idle_accept ? s_row_pixels_data : shift_q;
    assign src_xbase = idle_accept ? {1'b0, s_row_pixels_posX} : xbase_q;
    assign src_x     = idle_accept ? {1'b0, s_row_pixels_posX} : x_q;
    assign src_y     = idle_accept ? {1'b0, s_row_pixels_posY} : y_q;
    assign src_col   = idle_accept ? '0 : col_q;
    assign src_sxc   = idle_accept ? '0 : sxc_q;
    assign src_ryc   = idle_accept ? '0 : ryc_q;
    assign src_scx   = idle_accept ? in_scx : scx_q;
    assign src_fg    = idle_accept ? cfg_fg_color : fg_q;
    assign src_bg    = idle_accept ? cfg_bg_color : bg_q;
    assign src_bit   = src_shift[W-1];
    assign clipped   = (src_x >= 12'(SCREEN_WIDTH)) || (src_y >= 12'(SCREEN_HEIGHT));
    assign emit      = !clipped && !skip;

`ifdef OSD_TRANSPARENT_BG_EN
    logic tr_q, tr_d;
    assign skip = (idle_accept ? cfg_bg_transparent : tr_q) && !src_bit;
`else
    logic unused_bg_transparent;
    assign skip = 1'b0;
    assign unused_bg_transparent = cfg_bg_transparent;
`endif

    logic [W-1:0]       n_shift;
    logic [11:0]        n_x, n_y;
    logic [CW-1:0]      n_col;
    logic [SCALE_W-1:0] n_sxc, n_ry;

    always_comb begin
        state_d = state_q;
        row_d = row_q; shift_d = shift_q; xbase_d = xbase_q; x_d = x_q; y_d = y_q;
        col_d = col_q; sxc_d = sxc_q; ryc_d = ryc_q; scx_d = scx_q; scy_d = scy_q;
        fg_d = fg_q; bg_d = bg_q; ov_d = ov_q; od_d = od_q; ox_d = ox_q; oy_d = oy_q;
`ifdef OSD_TRANSPARENT_BG_EN
        tr_d = tr_q;
`endif
        n_sxc = src_sxc + SCALE_W'(1); n_col = src_col; n_x = src_x + 12'd1;
        n_y = src_y; n_ry = src_ryc; n_shift = src_shift;
        if (src_sxc == src_scx - SCALE_W'(1)) begin
            n_sxc = '0;
            if (src_col == CW'(W-1)) begin
                n_col = '0; n_x = src_xbase; n_y = src_y + 12'd1;
                n_ry = src_ryc + SCALE_W'(1); n_shift = src_row;
            end else begin
                n_col = src_col + CW'(1); n_shift = src_shift << 1;
            end
        end

        if (step) begin
            ov_d = emit;
            if (emit) begin
                od_d = src_bit ? src_fg : src_bg;
                ox_d = src_x[10:0];
                oy_d = src_y[10:0];
            end
        end else if (advance) begin
            ov_d = 1'b0;
        end

        if (accept) begin
            row_d = s_row_pixels_data; xbase_d = {1'b0, s_row_pixels_posX};
            scx_d = in_scx; scy_d = in_scy; fg_d = cfg_fg_color; bg_d = cfg_bg_color;
`ifdef OSD_TRANSPARENT_BG_EN
            tr_d = cfg_bg_transparent;
`endif
        end

        if (idle_accept) begin
            shift_d = n_shift; x_d = n_x; y_d = n_y; col_d = n_col; sxc_d = n_sxc; ryc_d = n_ry;
            state_d = S_EXPAND;
        end else if (state_q == S_EXPAND && advance) begin
            if (last_step && accept) begin
                shift_d = s_row_pixels_data; x_d = {1'b0, s_row_pixels_posX};
                y_d = {1'b0, s_row_pixels_posY}; col_d = '0; sxc_d = '0; ryc_d = '0;
            end else begin
                shift_d = n_shift; x_d = n_x; y_d = n_y; col_d = n_col; sxc_d = n_sxc; ryc_d = n_ry;
                if (last_step) state_d = S_IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            row_q <= '0; shift_q <= '0; xbase_q <= '0; x_q <= '0; y_q <= '0;
            col_q <= '0; sxc_q <= '0; ryc_q <= '0; scx_q <= SCALE_W'(1); scy_q <= SCALE_W'(1);
            fg_q <= '0; bg_q <= '0; ov_q <= 1'b0; od_q <= '0; ox_q <= '0; oy_q <= '0;
`ifdef OSD_TRANSPARENT_BG_EN
            tr_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            row_q <= row_d; shift_q <= shift_d; xbase_q <= xbase_d; x_q <= x_d; y_q <= y_d;
            col_q <= col_d; sxc_q <= sxc_d; ryc_q <= ryc_d; scx_q <= scx_d; scy_q <= scy_d;
            fg_q <= fg_d; bg_q <= bg_d; ov_q <= ov_d; od_q <= od_d; ox_q <= ox_d; oy_q <= oy_d;
`ifdef OSD_TRANSPARENT_BG_EN
            tr_q <= tr_d;
`endif
        end
    end

    assign m_pixel_valid = ov_q;
    assign m_pixel_data  = od_q;
    assign m_pixel_posX  = ox_q;
    assign m_pixel_posY  = oy_q;
endmodule

// File: tb/tb_char_row_scaler.sv
// Directed bench for char_row_scaler: scoreboard of expected beats, hold checks under
// backpressure, latency/back-to-back timing, clipping, config clamping and reset.
module tb_char_row_scaler;
    localparam int W = 9;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  cfg_scale_x, cfg_scale_y;
    logic [23:0] cfg_fg_color, cfg_bg_color;
    logic        cfg_bg_transparent;
    logic [W-1:0] s_data;
    logic        s_valid, s_ready;
    logic [10:0] s_posx, s_posy;
    logic [23:0] m_data;
    logic        m_valid;
    logic        m_ready = 1'b1;
    logic [10:0] m_posx, m_posy;

    always #5 clk = ~clk;

    char_row_scaler dut (
        .clk(clk), .rst(rst),
        .cfg_scale_x(cfg_scale_x), .cfg_scale_y(cfg_scale_y),
        .cfg_fg_color(cfg_fg_color), .cfg_bg_color(cfg_bg_color),
        .cfg_bg_transparent(cfg_bg_transparent),
        .s_row_pixels_data(s_data), .s_row_pixels_valid(s_valid),
        .s_row_pixels_ready(s_ready), .s_row_pixels_posX(s_posx),
        .s_row_pixels_posY(s_posy),
        .m_pixel_data(m_data), .m_pixel_valid(m_valid), .m_pixel_ready(m_ready),
        .m_pixel_posX(m_posx), .m_pixel_posY(m_posy)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    logic [45:0] exp_q[$];
    int beat_cnt = 0;
    int first_beat_cyc = -1;
    int last_beat_cyc = 0;
    int accept_cyc = 0;
    bit mon_en = 1'b0;
    bit bp_en  = 1'b0;
    logic prev_stall = 1'b0;
    logic [46:0] prev_beat = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    endtask

    // Downstream ready, driven just after the active edge.
    always @(posedge clk) begin
        #1;
        m_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Scoreboard and hold-stability monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (!rst && mon_en) begin
            if (prev_stall) check("hold", {m_valid, m_data, m_posx, m_posy}, prev_beat);
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) check("unexpected_beat", {1'b1, m_data, m_posx, m_posy}, 0);
                else check("beat", {m_data, m_posx, m_posy}, exp_q.pop_front());
                beat_cnt++;
                if (first_beat_cyc < 0) first_beat_cyc = cyc;
                last_beat_cyc = cyc;
            end
            prev_stall = m_valid && !m_ready;
            prev_beat  = {m_valid, m_data, m_posx, m_posy};
        end
    end

    function automatic int clampv(input int v);
        if (v == 0) return 1;
        if (v > 4) return 4;
        return v;
    endfunction

    task automatic model_row(input logic [W-1:0] data, input int x, input int y, input int sx,
                             input int sy, input logic [23:0] fg, input logic [23:0] bg,
                             input bit tr);
        int sxe, sye, px, py;
        bit b, drop;
        sxe = clampv(sx);
        sye = clampv(sy);
        for (int ry = 0; ry < sye; ry++)
            for (int col = 0; col < W; col++)
                for (int s = 0; s < sxe; s++) begin
                    px = x + col * sxe + s;
                    py = y + ry;
                    b = data[W-1-col];
                    drop = 1'b0;
`ifdef OSD_TRANSPARENT_BG_EN
                    drop = tr && !b;
`endif
                    if (px < 1920 && py < 1080 && !drop)
                        exp_q.push_back({b ? fg : bg, 11'(px), 11'(py)});
                end
    endtask

    // Called and returns at 1 time unit after a rising edge.
    task automatic send_row(input logic [W-1:0] data, input int x, input int y, input int sx,
                            input int sy, input logic [23:0] fg, input logic [23:0] bg,
                            input bit tr);
        int n = 0;
        s_data = data; s_posx = 11'(x); s_posy = 11'(y);
        cfg_scale_x = 3'(sx); cfg_scale_y = 3'(sy);
        cfg_fg_color = fg; cfg_bg_color = bg; cfg_bg_transparent = tr;
        s_valid = 1'b1;
        #1;
        while (!s_ready && n < 500) begin
            @(posedge clk); #2;
            n++;
        end
        if (n >= 500) check("accept_timeout", n, 0);
        @(posedge clk); #1;
        s_valid = 1'b0;
        accept_cyc = cyc;
        model_row(data, x, y, sx, sy, fg, bg, tr);
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain", exp_q.size(), 0);
        repeat (3) begin @(posedge clk); #1; end
    endtask

    task automatic reset_counts();
        beat_cnt = 0;
        first_beat_cyc = -1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("%0d/%0d checks passed", n_pass, n_checks + 1);
        $fatal(1);
    end

    initial begin
        int a1, a2, n;
        rst = 1'b1; s_valid = 1'b0; s_data = '0; s_posx = '0; s_posy = '0;
        cfg_scale_x = 3'd1; cfg_scale_y = 3'd1; cfg_fg_color = '0; cfg_bg_color = '0;
        cfg_bg_transparent = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_valid", m_valid, 0);
        check("rst_data", m_data, 0);
        check("rst_posx", m_posx, 0);
        check("rst_posy", m_posy, 0);
        check("rst_ready", s_ready, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        mon_en = 1'b1;

        // 1x1 row, second row queued back-to-back.
        reset_counts();
        send_row(9'b100000001, 100, 50, 1, 1, 24'hFFFFFF, 24'h000000, 1'b0);
        a1 = accept_cyc;
        send_row(9'b100000001, 100, 50, 1, 1, 24'hFFFFFF, 24'h000000, 1'b0);
        a2 = accept_cyc;
        wait_drain(100);
        check("s1_beats", beat_cnt, 18);
        check("s1_latency", first_beat_cyc, a1);
        check("s1_no_gap", last_beat_cyc - first_beat_cyc, 17);
        check("s1_b2b_accept", a2 - a1, 8);

        // 2x3 scaling, row-major order.
        reset_counts();
        send_row(9'b110000000, 0, 0, 2, 3, 24'h00FF00, 24'h0000AA, 1'b0);
        wait_drain(200);
        check("s2_beats", beat_cnt, 54);

        // Clipping at the bottom-right corner; the follow-up row measures completion.
        reset_counts();
        send_row(9'h1FF, 1915, 1079, 1, 2, 24'h112233, 24'h445566, 1'b0);
        a1 = accept_cyc;
        send_row(9'b100000001, 100, 50, 1, 1, 24'hFFFFFF, 24'h000000, 1'b0);
        a2 = accept_cyc;
        wait_drain(100);
        check("s3_beats", beat_cnt, 14);
        check("s3_clip_steps", a2 - a1, 17);

        // Backpressure on the first scenario.
        reset_counts();
        bp_en = 1'b1;
        send_row(9'b100000001, 100, 50, 1, 1, 24'hFFFFFF, 24'h000000, 1'b0);
        send_row(9'b100000001, 100, 50, 1, 1, 24'hFFFFFF, 24'h000000, 1'b0);
        wait_drain(500);
        bp_en = 1'b0;
        check("s4_beats", beat_cnt, 18);

        // Scale clamping and mid-row config change.
        reset_counts();
        send_row(9'b101100111, 300, 400, 0, 1, 24'hABCDEF, 24'h010203, 1'b0);
        wait_drain(100);
        check("sx0_beats", beat_cnt, 9);
        reset_counts();
        send_row(9'b101100111, 300, 400, 7, 1, 24'hABCDEF, 24'h010203, 1'b0);
        wait_drain(100);
        check("sx7_beats", beat_cnt, 36);
        reset_counts();
        send_row(9'b111100000, 200, 300, 2, 2, 24'hAAAAAA, 24'h555555, 1'b0);
        cfg_fg_color = 24'h123456;
        cfg_scale_x = 3'd1;
        wait_drain(100);
        check("midrow_beats", beat_cnt, 36);

        // Reset in the middle of a 2x2 row.
        reset_counts();
        send_row(9'b101010101, 10, 20, 2, 2, 24'hFEDCBA, 24'h0F0F0F, 1'b0);
        n = 0;
        while (beat_cnt < 5 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("pre_rst_beats", beat_cnt, 5);
        mon_en = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_ready", s_ready, 0);
        @(negedge clk);
        check("mid_rst_valid", m_valid, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        prev_stall = 1'b0;
        reset_counts();
        mon_en = 1'b1;
        send_row(9'b100000001, 100, 50, 1, 1, 24'hFFFFFF, 24'h000000, 1'b0);
        wait_drain(100);
        check("post_rst_beats", beat_cnt, 9);

        // Background transparency request (honoured only with the optional feature).
        reset_counts();
        send_row(9'b100000001, 100, 50, 1, 1, 24'hFFFFFF, 24'h000000, 1'b1);
        wait_drain(100);
`ifdef OSD_TRANSPARENT_BG_EN
        check("transp_beats", beat_cnt, 2);
`else
        check("transp_beats", beat_cnt, 9);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/char_row_scaler.md
Name: char_row_scaler

Overview:
- Next-generation pixel shifter for the character OSD path.
- Accepts one glyph row (CHAR_PIC_WIDTH bits plus screen position) from the glyph ROM stage.
- Expands each glyph bit into a scale_x by scale_y block of coloured pixels, clips against screen bounds, and streams out one pixel per cycle under valid/ready.
- Adds integer scaling, multi-bit colour and screen clipping, which the 1-bit shifter lacks.

Parameters:
- CHAR_PIC_WIDTH, 9, glyph row width in bits; bit [CHAR_PIC_WIDTH-1] is the leftmost pixel.
- SCALE_W, 3, width of the scale config ports.
- MAX_SCALE, 4, maximum scale factor per axis.
- COLOR_WIDTH, 24, output pixel colour width.
- SCREEN_WIDTH, 1920, horizontal clip bound.
- SCREEN_HEIGHT, 1080, vertical clip bound.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- cfg_scale_x  in  SCALE_W  horizontal scale. 0 is treated as 1; values above MAX_SCALE are clamped to MAX_SCALE.
- cfg_scale_y  in  SCALE_W  vertical scale, same rules as cfg_scale_x.
- cfg_fg_color  in  COLOR_WIDTH  colour for glyph bit 1.
- cfg_bg_color  in  COLOR_WIDTH  colour for glyph bit 0.
- cfg_bg_transparent  in  1  suppress background pixels (effective only with the optional feature).
- s_row_pixels_data  in  CHAR_PIC_WIDTH  glyph row bits.
- s_row_pixels_valid  in  1  input row valid.
- s_row_pixels_ready  out  1  input row accepted.
- s_row_pixels_posX  in  11  screen X of the row's left edge.
- s_row_pixels_posY  in  11  screen Y of the row's top scaled line.
- m_pixel_data  out  COLOR_WIDTH  pixel colour.
- m_pixel_valid  out  1  pixel valid.
- m_pixel_ready  in  1  downstream ready.
- m_pixel_posX  out  11  pixel X.
- m_pixel_posY  out  11  pixel Y.

Behaviour:
- Reset: m_pixel_valid=0, m_pixel_data=0, m_pixel_posX=0, m_pixel_posY=0, s_row_pixels_ready=0 while rst is high, FSM returns to IDLE.
- Reset mid-row discards the row; there are no partial outputs after reset deasserts.
- FSM states: IDLE and EXPAND.
  - IDLE: s_row_pixels_ready=1.
  - On s_row_pixels_valid && s_row_pixels_ready: latch data, posX, posY, clamped scales and both colours, then go to EXPAND.
  - Config changes during EXPAND have no effect on the current row.
- Expansion order, outermost to innermost:
  - ry in 0..sy-1;
  - col in 0..CHAR_PIC_WIDTH-1, MSB first;
  - sx in 0..sx_scale-1.
- Pixel position: x = posX + col*sx_scale + sx; y = posY + ry.
  - Computed with running 12-bit counters, not multipliers; there is no 11-bit wrap.
- Pixel colour = fg if the glyph bit is 1, else bg.
- Clipping: a step with x >= SCREEN_WIDTH or y >= SCREEN_HEIGHT takes one internal step and produces no output beat.
- Output stage:
  - Registered. The generator advances when the output register is empty or its beat is accepted (m_pixel_valid && m_pixel_ready).
  - While m_pixel_valid && !m_pixel_ready, data and position hold stable.
- Latency and throughput:
  - First pixel is valid on the cycle after row acceptance.
  - Sustained rate is 1 pixel/cycle with m_pixel_ready=1.
- Row completion:
  - On the final generator step the FSM returns to IDLE.
  - s_row_pixels_ready may assert in the same cycle the final step advances (combinational from the advance condition), so back-to-back rows have no bubble.
- A fully clipped row produces zero beats and completes after CHAR_PIC_WIDTH*sx_scale*sy internal steps.

Optional Feature:
- Macro: OSD_TRANSPARENT_BG_EN.
- Defined: when cfg_bg_transparent (latched at row acceptance) is 1, glyph-0 pixels are skipped like clipped pixels. Only foreground pixels are emitted, so a video mixer can overlay without a key colour.
- Undefined: cfg_bg_transparent is ignored and every unclipped pixel is emitted.

Test Plan:
- Scale 1x1, data 9'b100000001, pos (100,50), fg=FFFFFF, bg=000000, ready=1: 9 beats at x=100..108, y=50, colours FFFFFF, 7×000000, FFFFFF on consecutive cycles; a second queued row's first beat follows with no gap.
- Scale 2x3, data 9'b110000000, pos (0,0): 54 beats, rows y=0,1,2, x=0..17 per row; x=0..3 are fg, rest bg; order is row-major.
- Clipping, scale 1x2, pos (1915,1079), data all ones: only 5 beats, x=1915..1919 at y=1079. Row y=1080 produces none. s_row_pixels_ready returns high after 18 internal steps.
- Backpressure, m_pixel_ready toggling pseudo-randomly at 50% on the first scenario: data/pos never change while valid && !ready; accepted sequence is identical to the first scenario.
- Config rules: cfg_scale_x=0 gives 9 beats per row; cfg_scale_x=7 gives 36 beats per row (clamped to 4); changing cfg_fg_color mid-row leaves the current row's colour unchanged.
- Reset after 5 accepted beats of a 2x2 row: m_pixel_valid=0 the cycle after rst; after release, a new 1x1 row streams cleanly. With OSD_TRANSPARENT_BG_EN and cfg_bg_transparent=1, data 9'b100000001 emits only x=100 and x=108.
